// File: rtl/alu.sv
// Single-cycle registered integer ALU for the EX stage: eight operations, a zero flag,
// and an optional signed-overflow flag enabled by defining ALU_OVERFLOW_EN.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluop,
  output logic [WIDTH-1:0] out,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_SLT  = 3'd6,
    OP_SLTU = 3'd7
  } alu_op_e;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] result;
  logic             result_zero;

  assign sum         = a + b;
  assign diff        = a - b;
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    case (alu_op_e'(aluop))
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default: result = '0;
    endcase
  end

  // zero comes from the same next value as out so the two never disagree.
  assign result_zero = (result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      zero <= 1'b1;
    end else begin
      out  <= result;
      zero <= result_zero;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_next;

  always_comb begin
    ovf_next = 1'b0;
    case (alu_op_e'(aluop))
      OP_ADD:  ovf_next = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      OP_SUB:  ovf_next = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      default: ovf_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= ovf_next;
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized operations
// against an arithmetic reference model; covers the ALU_OVERFLOW_EN build when defined.
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   aluop;
  logic [W-1:0] out;
  logic         zero;
`ifdef ALU_OVERFLOW_EN
  logic         overflow;
`endif

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .aluop    (aluop),
    .out      (out),
`ifdef ALU_OVERFLOW_EN
    .overflow (overflow),
`endif
    .zero     (zero)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on sign/zero-extended 64-bit values.
  function automatic logic [W-1:0] ref_out(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] op);
    longint unsigned ux, uy, r;
    longint sx, sy;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'd0: r = ux + uy;
      3'd1: r = ux - uy;
      3'd2: r = ux & uy;
      3'd3: r = ux | uy;
      3'd4: r = ux ^ uy;
      3'd5: r = ~(ux | uy);
      3'd6: r = (sx < sy) ? 64'd1 : 64'd0;
      default: r = (ux < uy) ? 64'd1 : 64'd0;
    endcase
    return r[W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [2:0] op);
    longint sx, sy, r, smax, smin;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (W-1)) - 1;
    smin = -(longint'(1) <<< (W-1));
    if (op == 3'd0)      r = sx + sy;
    else if (op == 3'd1) r = sx - sy;
    else                 return 1'b0;
    return (r > smax) || (r < smin);
  endfunction

  // driver: apply one op mid-cycle, then check the registered result after the edge
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2:0] op);
    logic [W-1:0] e;
    logic         eo;
    @(negedge clk);
    a     = x;
    b     = y;
    aluop = op;
    exp_q.push_back(ref_out(x, y, op));
    exp_ovf_q.push_back(ref_ovf(x, y, op));
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    check({tag, ".out"}, 64'(out), 64'(e));
    check({tag, ".zero"}, 64'(zero), 64'(e == '0));
`ifdef ALU_OVERFLOW_EN
    check({tag, ".ovf"}, 64'(overflow), 64'(eo));
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out"}, 64'(out), 64'd0);
    check({tag, ".zero"}, 64'(zero), 64'd1);
`ifdef ALU_OVERFLOW_EN
    check({tag, ".ovf"}, 64'(overflow), 64'd0);
`endif
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = {1'b1, {(W-1){1'b0}}};
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = '1;
      4: v = W'($urandom_range(0, 15));
      default: v = W'($urandom());
    endcase
    return v;
  endfunction

  logic [W-1:0] ra, rb;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    a        = W'(5);
    b        = W'(7);
    aluop    = 3'd0;

    // reset applies immediately, without an edge
    #1 rst_n = 1'b0;
    #2;
    check_reset_state("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("rst_add", W'(5), W'(7), 3'd0);
    check("rst_add.12", 64'(out), 64'd12);

    // a=1, b=2 over ADD/SUB/AND/OR
    do_op("seq_add", W'(1), W'(2), 3'd0);
    check("seq_add.3", 64'(out), 64'd3);
    do_op("seq_sub", W'(1), W'(2), 3'd1);
    check("seq_sub.ff", 64'(out), 64'(W'('1)));
    do_op("seq_and", W'(1), W'(2), 3'd2);
    do_op("seq_or",  W'(1), W'(2), 3'd3);

    do_op("eq_sub", W'(3), W'(3), 3'd1);
    check("eq_sub.zero1", 64'(zero), 64'd1);
    do_op("eq_or",  W'(3), W'(3), 3'd3);

    do_op("slt_ext",  {1'b1, {(W-1){1'b0}}}, {1'b0, {(W-1){1'b1}}}, 3'd6);
    check("slt_ext.1", 64'(out), 64'd1);
    do_op("sltu_ext", {1'b1, {(W-1){1'b0}}}, {1'b0, {(W-1){1'b1}}}, 3'd7);
    check("sltu_ext.0", 64'(out), 64'd0);
    do_op("nor_zero", '0, '0, 3'd5);
    do_op("add_wrap", {1'b0, {(W-1){1'b1}}}, W'(1), 3'd0);
    do_op("sub_wrap", {1'b1, {(W-1){1'b0}}}, W'(1), 3'd1);
    do_op("sub_under", '0, W'(1), 3'd1);
    do_op("add_small", W'(1), W'(2), 3'd0);
    do_op("xor_self", W'(32'hA5A5_5A5A), W'(32'hA5A5_5A5A), 3'd4);

    // reset mid-operation drops the pending result
    @(negedge clk);
    a     = W'(9);
    b     = W'(4);
    aluop = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(posedge clk);
    #1;
    check_reset_state("rst_mid_edge");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", W'(20), W'(6), 3'd1);

    // randomized operations
    for (int i = 0; i < 300; i++) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 9) == 0) ? ra : pick_operand();
      do_op("rand", ra, rb, 3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
